// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch unit: holds the PC, fetches over a valid/ready request channel and hands one
// instruction at a time to decode. Define YSYX_22040365_IFU_MISALIGN_EN to trap misaligned redirects.
module ysyx_22040365_ifu #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            misalign
);

`ifdef YSYX_22040365_IFU_MISALIGN_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    ERR  = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;
`endif

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [31:0]     inst_q;
  logic            drop;
  logic [XLEN-1:0] target;
  logic            bad_target;
  logic            req_fire;

  assign req_fire = (state == REQ) && imem_req_ready;

`ifdef YSYX_22040365_IFU_MISALIGN_EN
  logic misalign_q;

  assign target     = redirect_pc;
  assign bad_target = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign misalign   = misalign_q;
`else
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] p);
    return p & ~XLEN'(2'b11);
  endfunction

  assign target     = align_pc(redirect_pc);
  assign bad_target = 1'b0;
  assign misalign   = 1'b0;
`endif

  // Fetch sequencer: PC, drop flag for stale responses and the held instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      inst_q <= 32'h0;
      drop   <= 1'b0;
`ifdef YSYX_22040365_IFU_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (redirect_valid) pc <= target;
          if (req_fire) begin
            state <= WAIT;
            drop  <= redirect_valid;
          end
        end
        WAIT: begin
          if (redirect_valid) pc <= target;
          if (imem_resp_valid) begin
            drop <= 1'b0;
            if (!drop && !redirect_valid) begin
              inst_q <= imem_resp_data;
              state  <= OUT;
            end else begin
              state <= REQ;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        OUT: begin
          if (redirect_valid) begin
            pc    <= target;
            state <= REQ;
          end else if (inst_ready) begin
            pc    <= pc + XLEN'(3'd4);
            state <= REQ;
          end
        end
`ifdef YSYX_22040365_IFU_MISALIGN_EN
        ERR: begin
          if (redirect_valid) begin
            pc         <= target;
            state      <= REQ;
            misalign_q <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
`ifdef YSYX_22040365_IFU_MISALIGN_EN
      // A misaligned target overrides whatever the state above chose; the ERR state ignores responses.
      if (bad_target && (state != IDLE)) begin
        state      <= ERR;
        drop       <= 1'b0;
        misalign_q <= 1'b1;
      end
`else
      if (bad_target) drop <= 1'b0;
`endif
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == OUT);
  assign inst           = inst_q;
  assign inst_pc        = pc;

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// Randomized bench for ysyx_22040365_ifu: a transaction-level model tracks the fetch stream,
// outstanding requests and the instruction owed to decode.
module tb_ysyx_22040365_ifu;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        misalign;

  ysyx_22040365_ifu #(.XLEN(64), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state: next fetch address, the one outstanding request, and the owed instruction.
  logic [63:0] exp_pc;
  bit          pending, pend_bad, holding, first, err;
  logic [63:0] pend_addr, hold_pc;
  logic [31:0] hold_data;
  int          resp_wait;
  int          delivered = 0;

  function automatic logic [63:0] landed(input logic [63:0] t);
`ifdef YSYX_22040365_IFU_MISALIGN_EN
    return t;
`else
    return t & ~64'h3;
`endif
  endfunction

  task automatic model_reset();
    exp_pc    = RST_PC;
    pending   = 1'b0;
    pend_bad  = 1'b0;
    holding   = 1'b0;
    err       = 1'b0;
    first     = 1'b1;
    resp_wait = 0;
  endtask

  task automatic check_reset_outputs();
    check_value("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check_value("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check_value("rst_misalign", {63'd0, misalign}, 64'd0);
    check_value("rst_req_addr", imem_req_addr, RST_PC);
    check_value("rst_inst", {32'd0, inst}, 64'd0);
    check_value("rst_inst_pc", inst_pc, RST_PC);
  endtask

  // Called mid-cycle: compare outputs with the model, then advance the model across the coming edge.
  task automatic step();
    bit          redir, mis, req_hs, dec_hs, resp;
    logic [63:0] t;
    check_value("req_valid", {63'd0, imem_req_valid}, {63'd0, (!first && !pending && !holding && !err)});
    if (imem_req_valid) check_value("req_addr", imem_req_addr, exp_pc);
    check_value("inst_valid", {63'd0, inst_valid}, {63'd0, holding});
    if (inst_valid && holding) begin
      check_value("inst", {32'd0, inst}, {32'd0, hold_data});
      check_value("inst_pc", inst_pc, hold_pc);
    end
    check_value("misalign", {63'd0, misalign}, {63'd0, err});

    redir  = redirect_valid;
    t      = landed(redirect_pc);
    mis    = 1'b0;
`ifdef YSYX_22040365_IFU_MISALIGN_EN
    mis    = redir && (redirect_pc[1:0] != 2'b00);
`endif
    req_hs = imem_req_valid && imem_req_ready;
    dec_hs = inst_valid && inst_ready;
    resp   = imem_resp_valid && pending;
    first  = 1'b0;

    if (resp) begin
      pending = 1'b0;
      if (!pend_bad && !redir && !err) begin
        holding   = 1'b1;
        hold_data = imem_resp_data;
        hold_pc   = pend_addr;
        delivered++;
      end
    end
    if (req_hs) begin
      pending   = 1'b1;
      pend_addr = exp_pc;
      pend_bad  = redir;
      resp_wait = $urandom_range(0, 2);
    end
    if (dec_hs && !redir) begin
      holding = 1'b0;
      exp_pc  = hold_pc + 64'd4;
    end
    if (redir) begin
      holding = 1'b0;
      if (pending) pend_bad = 1'b1;
      exp_pc = t;
      err    = mis;
    end
  endtask

  task automatic drive();
    bit allow;
    imem_req_ready = ($urandom_range(0, 9) < 7);
    inst_ready     = $urandom_range(0, 1) == 1;
    imem_resp_data = $urandom;
    if (pending && resp_wait == 0) begin
      imem_resp_valid = 1'b1;
    end else begin
      imem_resp_valid = 1'b0;
      if (pending) resp_wait--;
    end
    allow = 1'b1;
`ifdef YSYX_22040365_IFU_MISALIGN_EN
    allow = !pending;
`endif
    redirect_valid = allow && ($urandom_range(0, 11) == 0);
    case ($urandom_range(0, 3))
      0:       redirect_pc = RST_PC + 64'($urandom_range(0, 255)) * 64'd4;
      1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      2:       redirect_pc = {$urandom, $urandom};
      default: redirect_pc = 64'h8000_1000;
    endcase
  endtask

  initial begin
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'd0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    inst_ready      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      step();
      @(posedge clk);
      #1;
      drive();
      if (cyc == 1500) begin
        #2 rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rst             = 1'b0;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
      end
    end
    check_value("progress", {63'd0, (delivered > 100)}, 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_22040365_ifu.md
# ysyx_22040365_ifu

Instruction fetch unit for the ysyx_22040365 core. It holds the PC and issues fetch requests to instruction memory over a valid/ready request channel. It accepts the 32-bit response and presents it, with its PC, to decode over a valid/ready channel, then advances the PC by 4 or to a redirect target from execute. This block produces the `inst` word that the core top consumes.

## Interface
Parameters:
- `RESET_PC`, 64'h8000_0000: PC loaded at reset.
- `XLEN`, 64: PC/address width.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `redirect_valid` in 1: execute requests a PC change this cycle.
- `redirect_pc` in XLEN: redirect target.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out XLEN: fetch address, equal to the current PC.
- `imem_resp_valid` in 1: response valid, one cycle per accepted request; no back-pressure.
- `imem_resp_data` in 32: fetched instruction.
- `inst_valid` out 1: instruction available to decode.
- `inst_ready` in 1: decode takes the instruction.
- `inst` out 32: held instruction.
- `inst_pc` out XLEN: PC of the held instruction.
- `misalign` out 1: misaligned redirect flag (see Configuration).

## Operation
- State register `pc` (XLEN), instruction register (32), drop flag `drop` (1), FSM with states IDLE, REQ, WAIT, OUT, and ERR (ERR only with the macro).
- Reset: state=IDLE, `pc`=RESET_PC, `drop`=0, instruction register=0. All valid outputs and `misalign` are 0. `imem_req_addr`=RESET_PC; `inst`=0; `inst_pc`=RESET_PC.
- IDLE: always goes to REQ on the next edge.
- REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`.
  - On handshake: go to WAIT.
  - On `redirect_valid` without handshake: `pc`←`redirect_pc` and stay in REQ.
  - On `redirect_valid` with handshake in the same cycle: `pc`←`redirect_pc`, `drop`←1, go to WAIT.
- WAIT: waits for `imem_resp_valid`.
  - On `redirect_valid`: `pc`←`redirect_pc`, `drop`←1.
  - When the response arrives and neither `drop` nor `redirect_valid` is set: capture `imem_resp_data` and go to OUT.
  - Otherwise: discard the response, clear `drop`, go to REQ.
- OUT: `inst_valid`=1; `inst` and `inst_pc` are stable while waiting.
  - On `inst_ready` with no redirect: `pc`←`pc`+4 (mod 2^XLEN) and go to REQ.
  - On `redirect_valid` (regardless of `inst_ready`): `pc`←`redirect_pc` and go to REQ. If `inst_ready` was also high, the handshake still counts as a transfer.
- `inst_pc` is the PC register, which is unchanged from request through OUT.
- PC wrap: 0xFFFF_FFFF_FFFF_FFFC + 4 → 0.
- Reset asserted mid-operation: immediate return to reset values. Any outstanding response after reset release is ignored, because IDLE/REQ do not sample `imem_resp_valid`.

## Timing
- Request accepted at edge N. Response no earlier than cycle N+1. `inst_valid` rises the cycle after the response. Next request is issued the cycle after the decode handshake.
- Best-case throughput is 1 instruction per 3 cycles.
- `imem_req_valid` and `inst_valid` are decoded from state only; they have no combinational path from any input.
- Redirect takes effect at the next edge. The first request to the new target is issued in the next REQ cycle.

## Configuration
- Macro `YSYX_22040365_IFU_MISALIGN_EN`, defined:
  - A redirect with `redirect_pc[1:0]`≠0 loads `pc` and goes to ERR, overriding the state's normal next state. Any pending response is discarded.
  - ERR: no requests, `inst_valid`=0, `misalign`=1.
  - ERR exits only on an aligned redirect: go to REQ, `misalign`←0.
- Macro undefined:
  - `redirect_pc[1:0]` is forced to 0 when loaded.
  - `misalign` is tied to 0.
  - No ERR state.

## Test plan
- Reset release, memory always ready with 1-cycle response 0x00000013 → first request addr 0x80000000. Consecutive `inst_pc` values 0x80000000, 0x80000004, 0x80000008, each with `inst`=0x00000013.
- `inst_ready` held low for 5 cycles in OUT → `inst_valid` stays 1. `inst`, `inst_pc` and `imem_req_valid`=0 are all stable, and no PC advance.
- Redirect to 0x80001000 during WAIT, response 0xDEADBEEF arrives 2 cycles later → response dropped. Next request addr 0x80001000, and `inst_valid` never shows 0xDEADBEEF.
- Redirect to 0x80002000 in the same cycle as the request handshake → WAIT response dropped, then request addr 0x80002000.
- PC near wrap: redirect to 0xFFFFFFFFFFFFFFFC, one instruction consumed → next request addr 0x0.
- With the macro: redirect to 0x80000002 → `misalign`=1 and no requests. A later redirect to 0x80000010 clears `misalign` and requests 0x80000010. Without the macro, the same stimulus requests 0x80000000.
